stopwatch_sequencer: RTL and testbench

Control front end for the stopwatch counter. It turns two user buttons (start/stop toggle, lap/clear) into single-cycle `sw_start`, `sw_stop` and `sw_reset` pulses for the stopwatch. It also captures lap times from the stopwatch `count` into a small show-ahead buffer that software or display logic drains over a valid/ready handshake. It sits between the button-conditioning logic and the stopwatch datapath.

---
 rtl/stopwatch_sequencer.sv | 139 +++++++++++++
 tb/tb_stopwatch_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control front end: turns start/stop and lap/clear button edges into
// stopwatch command pulses and buffers lap times in a show-ahead FIFO.
module stopwatch_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          btn_ss,
    input  logic                          btn_lr,
    input  logic [DATA_WIDTH-1:0]         count,
    output logic                          sw_start,
    output logic                          sw_stop,
    output logic                          sw_reset,
    output logic                          running,
    output logic [DATA_WIDTH-1:0]         lap_data,
    output logic                          lap_valid,
    input  logic                          lap_ready,
    output logic [$clog2(LAP_DEPTH):0]    lap_level,
    output logic                          lap_overflow
);

    localparam int AW = $clog2(LAP_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t state_reg, state_next;
    logic   ss_q_reg, lr_q_reg;
    logic   ss_e, lr_e;
    logic   start_reg, stop_reg, reset_reg;
    logic   start_next, stop_next, reset_next;
    logic   push, flush;

    assign ss_e = btn_ss & ~ss_q_reg;
    assign lr_e = btn_lr & ~lr_q_reg;

    // State, edge-detect history and registered command pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            ss_q_reg  <= 1'b0;
            lr_q_reg  <= 1'b0;
            start_reg <= 1'b0;
            stop_reg  <= 1'b0;
            reset_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            ss_q_reg  <= btn_ss;
            lr_q_reg  <= btn_lr;
            start_reg <= start_next;
            stop_reg  <= stop_next;
            reset_reg <= reset_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ss_e) state_next = RUN;
            RUN:     if (ss_e) state_next = PAUSE;
            PAUSE: begin
                if (lr_e)      state_next = IDLE;
                else if (ss_e) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear beats start when both buttons rise together in PAUSE
    always_comb begin
        start_next = 1'b0;
        stop_next  = 1'b0;
        reset_next = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_reg)
            IDLE:  start_next = ss_e;
            RUN: begin
                stop_next = ss_e;
                push      = lr_e;
            end
            PAUSE: begin
                reset_next = lr_e;
                flush      = lr_e;
                start_next = ss_e & ~lr_e;
            end
            default: ;
        endcase
    end

    assign sw_start = start_reg;
    assign sw_stop  = stop_reg;
    assign sw_reset = reset_reg;
    assign running  = (state_reg == RUN);

    logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]         level_reg;
    logic                  ovf_reg;
    logic                  full, pop, push_ok, drop;

    assign full    = (level_reg == LW'(LAP_DEPTH));
    assign pop     = (level_reg != '0) & lap_ready;
    // A pop frees the slot in the same cycle, so a full buffer still accepts
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push_ok && !pop)      level_reg <= level_reg + LW'(1);
            else if (!push_ok && pop) level_reg <= level_reg - LW'(1);
            if (drop) ovf_reg <= 1'b1;
        end
    end

    // Lap storage carries no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr_reg] <= count;
    end

    assign lap_data     = mem[rd_ptr_reg];
    assign lap_valid    = (level_reg != '0);
    assign lap_level    = level_reg;
    assign lap_overflow = ovf_reg;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Bench for stopwatch_sequencer: queue-based behavioural model checked every cycle,
// driven by a directed scenario with literal spot checks.
module tb_stopwatch_sequencer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          btn_ss = 1'b0, btn_lr = 1'b0, lap_ready = 1'b0;
    logic [DW-1:0] count = '0;
    logic          sw_start, sw_stop, sw_reset, running, lap_valid, lap_overflow;
    logic [DW-1:0] lap_data;
    logic [2:0]    lap_level;

    int checks = 0;
    int errors = 0;

    stopwatch_sequencer #(.DATA_WIDTH(DW), .LAP_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .btn_ss(btn_ss), .btn_lr(btn_lr), .count(count),
        .sw_start(sw_start), .sw_stop(sw_stop), .sw_reset(sw_reset), .running(running),
        .lap_data(lap_data), .lap_valid(lap_valid), .lap_ready(lap_ready),
        .lap_level(lap_level), .lap_overflow(lap_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode number plus a queue of laps
    int            m_mode = 0;          // 0 idle, 1 run, 2 pause
    bit            m_ssq = 0, m_lrq = 0, m_start = 0, m_stop = 0, m_reset = 1, m_ovf = 0;
    logic [DW-1:0] q[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mode = 0; m_ssq = 0; m_lrq = 0;
            m_start = 0; m_stop = 0; m_reset = 1; m_ovf = 0;
            q.delete();
        end else begin
            bit ss, lr, pop, push, clr;
            ss  = btn_ss && !m_ssq;
            lr  = btn_lr && !m_lrq;
            pop = (q.size() > 0) && lap_ready;
            m_ssq = btn_ss; m_lrq = btn_lr;
            m_start = 0; m_stop = 0; m_reset = 0;
            push = 0; clr = 0;
            if (m_mode == 0) begin
                if (ss) begin m_mode = 1; m_start = 1; end
            end else if (m_mode == 1) begin
                push = lr;
                if (ss) begin m_mode = 2; m_stop = 1; end
            end else begin
                if (lr) begin m_mode = 0; m_reset = 1; clr = 1; end
                else if (ss) begin m_mode = 1; m_start = 1; end
            end
            if (clr) begin
                q.delete();
                m_ovf = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    if (q.size() < DEPTH) q.push_back(count);
                    else m_ovf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("sw_start", int'(sw_start), int'(m_start));
        check("sw_stop", int'(sw_stop), int'(m_stop));
        check("sw_reset", int'(sw_reset), int'(m_reset));
        check("running", int'(running), int'(m_mode == 1));
        check("lap_valid", int'(lap_valid), int'(q.size() > 0));
        check("lap_level", int'(lap_level), q.size());
        check("lap_overflow", int'(lap_overflow), int'(m_ovf));
        if (q.size() > 0) check("lap_data", int'(lap_data), int'(q[0]));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic lap(input int v);
        count = DW'(v); btn_lr = 1'b1; cyc();
        btn_lr = 1'b0; cyc();
    endtask

    task automatic press_ss();
        btn_ss = 1'b1; cyc();
        btn_ss = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        check("lit_reset_sw_reset", int'(sw_reset), 1);
        check("lit_reset_level", int'(lap_level), 0);
        resetn = 1'b1;
        cyc();
        check("lit_post_reset_sw_reset", int'(sw_reset), 0);
        check("lit_post_reset_running", int'(running), 0);

        // held start button gives one pulse
        btn_ss = 1'b1; cyc();
        check("lit_start_pulse", int'(sw_start), 1);
        check("lit_start_running", int'(running), 1);
        repeat (4) begin cyc(); check("lit_start_once", int'(sw_start), 0); end
        btn_ss = 1'b0; cyc();
        press_ss();
        check("lit_stop_pulse", int'(sw_stop), 1);
        check("lit_stop_running", int'(running), 0);
        cyc();

        press_ss(); cyc();
        lap(12); lap(37); lap(99);
        check("lit_level3", int'(lap_level), 3);
        lap_ready = 1'b1;
        check("lit_lap0", int'(lap_data), 12); cyc();
        check("lit_lap1", int'(lap_data), 37); cyc();
        check("lit_lap2", int'(lap_data), 99); cyc();
        check("lit_drained", int'(lap_valid), 0);
        lap_ready = 1'b0;

        for (int i = 1; i <= 6; i++) lap(i);
        check("lit_ovf_level", int'(lap_level), 4);
        check("lit_ovf_flag", int'(lap_overflow), 1);
        lap_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("lit_ovf_drain", int'(lap_data), i); cyc();
        end
        lap_ready = 1'b0;

        // clear from PAUSE with two laps and overflow pending
        lap(50); lap(51);
        press_ss(); cyc();
        btn_lr = 1'b1; cyc(); btn_lr = 1'b0;
        check("lit_clear_pulse", int'(sw_reset), 1);
        check("lit_clear_level", int'(lap_level), 0);
        check("lit_clear_ovf", int'(lap_overflow), 0);
        cyc();
        btn_lr = 1'b1; cyc(); btn_lr = 1'b0;
        check("lit_idle_lr_reset", int'(sw_reset), 0);
        check("lit_idle_lr_running", int'(running), 0);
        cyc();

        // push into a full buffer while popping
        press_ss(); cyc();
        for (int i = 1; i <= 4; i++) lap(i);
        count = 16'd5; btn_lr = 1'b1; lap_ready = 1'b1; cyc();
        btn_lr = 1'b0; lap_ready = 1'b0;
        check("lit_fullpop_level", int'(lap_level), 4);
        check("lit_fullpop_ovf", int'(lap_overflow), 0);
        check("lit_fullpop_head", int'(lap_data), 2);
        cyc();
        lap_ready = 1'b1; repeat (4) cyc(); lap_ready = 1'b0;

        count = 16'd42; btn_ss = 1'b1; btn_lr = 1'b1; cyc();
        btn_ss = 1'b0; btn_lr = 1'b0;
        check("lit_both_run_stop", int'(sw_stop), 1);
        check("lit_both_run_lap", int'(lap_data), 42);
        check("lit_both_run_level", int'(lap_level), 1);
        cyc();
        btn_ss = 1'b1; btn_lr = 1'b1; cyc();
        btn_ss = 1'b0; btn_lr = 1'b0;
        check("lit_both_pause_reset", int'(sw_reset), 1);
        check("lit_both_pause_start", int'(sw_start), 0);
        check("lit_both_pause_running", int'(running), 0);
        cyc();

        // reset in the middle of a run
        press_ss(); cyc();
        lap(77);
        #3 resetn = 1'b0;
        cyc();
        check("lit_midreset_level", int'(lap_level), 0);
        check("lit_midreset_sw_reset", int'(sw_reset), 1);
        #3 resetn = 1'b1;
        cyc();
        check("lit_midreset_release", int'(sw_reset), 0);
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
